// File: rtl/mips_ad_pkg.sv
// Shared types and default memory map for the MIPS address-decode controller.
package mips_ad_pkg;

    // Controller phases: waiting for a request, driving a slave, answering the CPU.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Standard MIPS map: RAM at page 0x00, then GPIO / timer / UART-style peripherals.
    localparam int DEF_NUM_SLAVES = 4;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_PAGE_LSB   = 8;
    localparam int DEF_WS_W       = 4;
    localparam int DEF_PAGE_W     = DEF_ADDR_W - DEF_PAGE_LSB;

    // Slave 0 occupies the least significant field of each packed table.
    localparam logic [DEF_NUM_SLAVES*DEF_PAGE_W-1:0] DEF_SLAVE_PAGE =
        {24'h00000A, 24'h000009, 24'h000008, 24'h000000};
    localparam logic [DEF_NUM_SLAVES*DEF_WS_W-1:0] DEF_SLAVE_WAIT =
        {4'd1, 4'd1, 4'd1, 4'd0};

    // Width of a slave index; a single-slave map still needs a 1-bit index signal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mips_ad_match.sv
// Page comparator: flags whether a page is mapped and which slave owns it.
module mips_ad_match
    import mips_ad_pkg::*;
#(
    parameter int                            NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int                            PAGE_W     = DEF_PAGE_W,
    parameter logic [NUM_SLAVES*PAGE_W-1:0]  SLAVE_PAGE = DEF_SLAVE_PAGE,
    parameter int                            IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [PAGE_W-1:0] page,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Scan from the highest entry down so the lowest matching index is the last write and wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (page == SLAVE_PAGE[i*PAGE_W +: PAGE_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mips_ad_ctrl.sv
// Sequential memory-map controller: decodes the CPU page, runs a req/ready
// handshake with per-slave wait states, registers read data and logs the
// first unmapped access in a sticky fault register.
module mips_ad_ctrl
    import mips_ad_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PAGE_LSB   = DEF_PAGE_LSB,
    parameter int WS_W       = DEF_WS_W,
    parameter logic [NUM_SLAVES*(ADDR_W-PAGE_LSB)-1:0] SLAVE_PAGE = DEF_SLAVE_PAGE,
    parameter logic [NUM_SLAVES*WS_W-1:0]              SLAVE_WAIT = DEF_SLAVE_WAIT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    output logic                         cpu_ready,
    output logic                         cpu_err,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic [ADDR_W-1:0]            slave_addr,
    output logic [NUM_SLAVES-1:0]        slave_sel,
    output logic [NUM_SLAVES-1:0]        slave_we,
    input  logic [NUM_SLAVES*DATA_W-1:0] slave_rdata,
    output logic                         fault_valid,
    output logic [ADDR_W-1:0]            fault_addr,
    input  logic                         fault_clr
);

    localparam int PAGE_W = ADDR_W - PAGE_LSB;
    localparam int IDX_W  = idx_width(NUM_SLAVES);

    state_t              state_q,       state_d;
    logic [ADDR_W-1:0]   addr_q,        addr_d;
    logic                we_q,          we_d;
    logic [IDX_W-1:0]    idx_q,         idx_d;
    logic                miss_q,        miss_d;
    logic [WS_W-1:0]     cnt_q,         cnt_d;
    logic [DATA_W-1:0]   rdata_q,       rdata_d;
    logic                fault_valid_q, fault_valid_d;
    logic [ADDR_W-1:0]   fault_addr_q,  fault_addr_d;

    logic                match_hit;
    logic [IDX_W-1:0]    match_idx;
    logic [WS_W-1:0]     load_wait;
    logic [DATA_W-1:0]   sel_rdata;
    logic                accept;

    mips_ad_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .PAGE_W     (PAGE_W),
        .SLAVE_PAGE (SLAVE_PAGE),
        .IDX_W      (IDX_W)
    ) u_match (
        .page (cpu_addr[ADDR_W-1:PAGE_LSB]),
        .hit  (match_hit),
        .idx  (match_idx)
    );

    // A request is only ever taken in IDLE; req/addr in any other state are ignored.
    assign accept = (state_q == IDLE) && cpu_req;

    // Look up the wait-state count of the slave being decoded right now.
    always_comb begin
        load_wait = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (match_idx == IDX_W'(i)) begin
                load_wait = SLAVE_WAIT[i*WS_W +: WS_W];
            end
        end
    end

    // Route the read bus of the latched slave towards the read-data register.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdata = slave_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake FSM next state, request latch, wait counter and read-data capture.
    always_comb begin
        // NOTE: combinational logic uses blocking '=', the flop block below uses non-blocking '<='.
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        idx_d   = idx_q;
        miss_d  = miss_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = cpu_addr;
                    we_d   = cpu_we;
                    idx_d  = match_idx;
                    miss_d = !match_hit;
                    if (match_hit) begin
                        cnt_d   = load_wait;
                        state_d = ACCESS;
                    end else begin
                        // Unmapped: answer next cycle with zero data and the error flag.
                        cnt_d   = '0;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WS_W'(1);
                end else begin
                    // Last access cycle: a write returns zero, a read samples the slave.
                    rdata_d = we_q ? '0 : sel_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky fault log: first miss is kept; a miss coincident with a clear overrides the clear.
    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_addr_d  = fault_addr_q;
        if (accept && !match_hit && (!fault_valid_q || fault_clr)) begin
            fault_valid_d = 1'b1;
            fault_addr_d  = cpu_addr;
        end else if (fault_clr) begin
            fault_valid_d = 1'b0;
            fault_addr_d  = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, since every visible output must read zero after reset.
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            we_q          <= 1'b0;
            idx_q         <= '0;
            miss_q        <= 1'b0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            idx_q         <= idx_d;
            miss_q        <= miss_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    // Slave-side strobes; gating with rst_n makes a reset in the final access cycle abort the write.
    always_comb begin
        slave_sel = '0;
        slave_we  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if ((state_q == ACCESS) && (idx_q == IDX_W'(i))) begin
                slave_sel[i] = 1'b1;
                slave_we[i]  = rst_n && we_q && (cnt_q == '0);
            end
        end
    end

    // CPU-side response, driven only from latched values.
    always_comb begin
        cpu_ready   = rst_n && (state_q == RESP);
        cpu_err     = cpu_ready && miss_q;
        cpu_rdata   = rdata_q;
        slave_addr  = addr_q;
        fault_valid = fault_valid_q;
        fault_addr  = fault_addr_q;
    end

endmodule

// File: tb/tb_mips_ad_ctrl.sv
// Self-checking bench for mips_ad_ctrl. A five-entry map adds an overlapping
// page (slave 4 shadows slave 1) and a slave at the maximum wait count.
module tb_mips_ad_ctrl;

    localparam int NS = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PL = 8;
    localparam int WW = 4;
    localparam int PW = AW - PL;

    localparam logic [NS*PW-1:0] TB_PAGES =
        {24'h000008, 24'h00000A, 24'h000009, 24'h000008, 24'h000000};
    localparam logic [NS*WW-1:0] TB_WAITS =
        {4'd2, 4'd15, 4'd1, 4'd1, 4'd0};

    // Reference view of the same map as plain tables.
    int unsigned ref_page [NS] = '{32'h0, 32'h8, 32'h9, 32'hA, 32'h8};
    int          ref_wait [NS] = '{0, 1, 1, 15, 2};

    logic              clk;
    logic              rst_n;
    logic              cpu_req;
    logic              cpu_we;
    logic [AW-1:0]     cpu_addr;
    logic              cpu_ready;
    logic              cpu_err;
    logic [DW-1:0]     cpu_rdata;
    logic [AW-1:0]     slave_addr;
    logic [NS-1:0]     slave_sel;
    logic [NS-1:0]     slave_we;
    logic [NS*DW-1:0]  slave_rdata;
    logic              fault_valid;
    logic [AW-1:0]     fault_addr;
    logic              fault_clr;

    logic [DW-1:0]     rd_bank [NS];

    int n_cmp = 0;
    int n_bad = 0;

    // Fault-log model.
    logic          m_fv;
    logic [AW-1:0] m_fa;

    mips_ad_ctrl #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .PAGE_LSB   (PL),
        .WS_W       (WW),
        .SLAVE_PAGE (TB_PAGES),
        .SLAVE_WAIT (TB_WAITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_ready   (cpu_ready),
        .cpu_err     (cpu_err),
        .cpu_rdata   (cpu_rdata),
        .slave_addr  (slave_addr),
        .slave_sel   (slave_sel),
        .slave_we    (slave_we),
        .slave_rdata (slave_rdata),
        .fault_valid (fault_valid),
        .fault_addr  (fault_addr),
        .fault_clr   (fault_clr)
    );

    for (genvar g = 0; g < NS; g++) begin : g_bank
        assign slave_rdata[g*DW +: DW] = rd_bank[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lowest-numbered slave whose page equals the address page, or -1 when unmapped.
    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a >> PL) == ref_page[i]) return i;
        end
        return -1;
    endfunction

    // Fault-log rule applied at the moment a request is accepted.
    task automatic model_fault(input logic [AW-1:0] a, input logic clr);
        if (ref_decode(a) < 0 && (!m_fv || clr)) begin
            m_fv = 1'b1;
            m_fa = a;
        end else if (clr) begin
            m_fv = 1'b0;
            m_fa = '0;
        end
    endtask

    // One complete transaction from an IDLE negedge, checked against the model.
    task automatic run_txn(input string tag, input logic [AW-1:0] a, input logic we,
                           input logic clr, input bit keep_bank);
        int idx, lat_exp, sel_exp, k, sel_cnt, we_cnt, we_at, bad_sel;
        logic got_ready, got_err;
        logic [DW-1:0] got_rdata, exp_rdata;
        logic [AW-1:0] got_saddr;
        idx = ref_decode(a);
        lat_exp = (idx < 0) ? 1 : ref_wait[idx] + 2;
        sel_exp = (idx < 0) ? 0 : ref_wait[idx] + 1;
        if (!keep_bank) begin
            for (int i = 0; i < NS; i++) rd_bank[i] = $urandom;
        end
        exp_rdata = (idx >= 0 && !we) ? rd_bank[idx] : '0;
        model_fault(a, clr);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; fault_clr = clr;
        k = 0; sel_cnt = 0; we_cnt = 0; we_at = -1; bad_sel = 0;
        got_ready = 1'b0; got_err = 1'b0; got_rdata = '0; got_saddr = '0;
        while (!got_ready && k < 40) begin
            @(negedge clk);
            k++;
            cpu_req = 1'b0; fault_clr = 1'b0;
            cpu_addr = $urandom; cpu_we = 1'($urandom_range(0, 1));
            for (int i = 0; i < NS; i++) begin
                if (slave_sel[i]) begin
                    if (i == idx) sel_cnt++; else bad_sel++;
                end
                if (slave_we[i]) begin
                    if (i == idx) begin we_cnt++; we_at = k; end else bad_sel++;
                end
            end
            if (cpu_ready) begin
                got_ready = 1'b1; got_err = cpu_err;
                got_rdata = cpu_rdata; got_saddr = slave_addr;
            end
        end
        n_cmp++;
        if (k !== lat_exp) begin
            n_bad++; $display("FAIL %s latency: got %0d expected %0d", tag, k, lat_exp);
        end
        n_cmp++;
        if (got_err !== (idx < 0)) begin
            n_bad++; $display("FAIL %s err: got %0b expected %0b", tag, got_err, idx < 0);
        end
        n_cmp++;
        if (got_rdata !== exp_rdata) begin
            n_bad++; $display("FAIL %s rdata: got %h expected %h", tag, got_rdata, exp_rdata);
        end
        n_cmp++;
        if (got_saddr !== a) begin
            n_bad++; $display("FAIL %s slave_addr: got %h expected %h", tag, got_saddr, a);
        end
        n_cmp++;
        if (sel_cnt !== sel_exp) begin
            n_bad++; $display("FAIL %s sel cycles: got %0d expected %0d", tag, sel_cnt, sel_exp);
        end
        n_cmp++;
        if (bad_sel !== 0) begin
            n_bad++; $display("FAIL %s stray sel/we: got %0d expected 0", tag, bad_sel);
        end
        n_cmp++;
        if (we_cnt !== ((idx >= 0 && we) ? 1 : 0)) begin
            n_bad++; $display("FAIL %s we pulses: got %0d expected %0d", tag, we_cnt,
                              (idx >= 0 && we) ? 1 : 0);
        end
        if (idx >= 0 && we) begin
            n_cmp++;
            if (we_at !== sel_exp) begin
                n_bad++; $display("FAIL %s we cycle: got %0d expected %0d", tag, we_at, sel_exp);
            end
        end
        n_cmp++;
        if (fault_valid !== m_fv || fault_addr !== m_fa) begin
            n_bad++; $display("FAIL %s fault: got %0b/%h expected %0b/%h", tag,
                              fault_valid, fault_addr, m_fv, m_fa);
        end
        @(negedge clk);
        n_cmp++;
        if (cpu_ready !== 1'b0 || cpu_rdata !== exp_rdata) begin
            n_bad++; $display("FAIL %s after resp: got ready=%0b rdata=%h expected 0/%h", tag,
                              cpu_ready, cpu_rdata, exp_rdata);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if ({cpu_ready, cpu_err, slave_sel, slave_we, fault_valid} !== '0 ||
            cpu_rdata !== '0 || slave_addr !== '0 || fault_addr !== '0) begin
            n_bad++;
            $display("FAIL %s outputs: got rdy=%0b err=%0b rd=%h sa=%h sel=%b we=%b fv=%0b fa=%h expected all 0",
                     tag, cpu_ready, cpu_err, cpu_rdata, slave_addr, slave_sel, slave_we,
                     fault_valid, fault_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; fault_clr = 1'b0;
        for (int i = 0; i < NS; i++) rd_bank[i] = '0;
        m_fv = 1'b0; m_fa = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_read_ram();
        rd_bank[0] = 32'hDEADBEEF;
        run_txn("read_ram", 32'h0000_0010, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_write_gpio();
        run_txn("write_gpio", 32'h0000_0804, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_unmapped();
        run_txn("unmapped", 32'h0000_1000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fault_log();
        run_txn("second_miss", 32'h0000_2000, 1'b0, 1'b0, 1'b0);
        run_txn("clr_with_miss", 32'h0000_3000, 1'b1, 1'b1, 1'b0);
        run_txn("clr_with_hit", 32'h0000_0020, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_boundaries();
        // Overlap: page 0x08 also appears in slave 4 (wait 2); slave 1 (wait 1) must win.
        run_txn("overlap", 32'h0000_08F0, 1'b0, 1'b0, 1'b0);
        // Maximum wait count.
        run_txn("max_wait_rd", 32'h0000_0A00, 1'b0, 1'b0, 1'b0);
        run_txn("max_wait_wr", 32'h0000_0AFC, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        int hits;
        for (int i = 0; i < NS; i++) rd_bank[i] = $urandom;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0900;
        @(negedge clk);
        cpu_req = 1'b0;
        n_cmp++;
        if (slave_sel !== NS'(5'b00100)) begin
            n_bad++; $display("FAIL abort in_access sel: got %b expected 00100", slave_sel);
        end
        rst_n = 1'b0;
        m_fv = 1'b0; m_fa = '0;
        hits = (slave_we != '0 || cpu_ready) ? 1 : 0;
        @(negedge clk);
        check_all_zero("abort_reset");
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (slave_we != '0 || cpu_ready) hits++;
        end
        n_cmp++;
        if (hits !== 0) begin
            n_bad++; $display("FAIL abort strobes: got %0d cycles with we/ready expected 0", hits);
        end
        run_txn("after_abort", 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] seq [4];
        int n, k, cyc, lat, unstable, idx;
        seq[0] = 32'h0000_0904; seq[1] = 32'h0000_0020;
        seq[2] = 32'h0000_7700; seq[3] = 32'h0000_0808;
        for (int i = 0; i < NS; i++) rd_bank[i] = $urandom;
        n = 0; k = 0; cyc = 0; unstable = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = seq[0];
        model_fault(seq[0], 1'b0);
        while (n < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++; k++;
            idx = ref_decode(seq[n]);
            lat = (idx < 0) ? 1 : ref_wait[idx] + 2;
            if (cpu_ready) begin
                n_cmp++;
                if (k !== lat) begin
                    n_bad++; $display("FAIL b2b[%0d] latency: got %0d expected %0d", n, k, lat);
                end
                n_cmp++;
                if (slave_addr !== seq[n] || cpu_err !== (idx < 0)) begin
                    n_bad++; $display("FAIL b2b[%0d] resp: got addr=%h err=%0b expected %h/%0b",
                                      n, slave_addr, cpu_err, seq[n], idx < 0);
                end
                n++;
                k = -1;
                if (n < 4) begin
                    cpu_addr = seq[n];
                    model_fault(seq[n], 1'b0);
                end else begin
                    cpu_req = 1'b0;
                end
            end else if (k >= 1) begin
                if (slave_addr !== seq[n]) unstable++;
                cpu_addr = $urandom;
            end
        end
        cpu_req = 1'b0;
        n_cmp++;
        if (n !== 4) begin
            n_bad++; $display("FAIL b2b responses: got %0d expected 4", n);
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_bad++; $display("FAIL b2b latched addr moved: got %0d cycles expected 0", unstable);
        end
        @(negedge clk);
        n_cmp++;
        if (cpu_ready !== 1'b0 || fault_valid !== m_fv || fault_addr !== m_fa) begin
            n_bad++; $display("FAIL b2b tail: got rdy=%0b fv=%0b fa=%h expected 0/%0b/%h",
                              cpu_ready, fault_valid, fault_addr, m_fv, m_fa);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int kind;
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, NS);
            if (kind < NS) a = {ref_page[kind][PW-1:0], 8'($urandom)};
            else           a = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn($sformatf("rand%0d", t), a, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_read_ram();
        test_write_gpio();
        test_unmapped();
        test_fault_log();
        test_boundaries();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
